crc_frame_checker: RTL and testbench

//  Self-sequenced CRC checker for frames of tagged codewords held in on-chip RAM. Each word is {tag[1:0], msg, crc}.

---
 rtl/crc_chk_pkg.sv | 21 ++
 rtl/crc_serial_div.sv | 39 +++
 rtl/crc_frame_checker.sv | 157 +++++++++++++++
 tb/tb_crc_frame_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_chk_pkg.sv
// Shared definitions for the CRC frame checker: FSM states, word tags and word-width helper.
package crc_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_LOAD,
    S_DIV,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [1:0] TAG_TERM = 2'b11;
  localparam logic [1:0] TAG_DATA = 2'b01;

  function automatic int word_width(input int msg_len, input int crc_len);
    return msg_len + crc_len + 2;
  endfunction

endpackage

// File: rtl/crc_serial_div.sv
// Bit-serial polynomial divider: loads a codeword, then shifts it MSB first through a
// CRC_LEN-bit LFSR. rem_next is the remainder after the bit currently at the head is consumed.
module crc_serial_div #(
  parameter int MSG_LEN = 10,
  parameter int CRC_LEN = 4,
  parameter logic [CRC_LEN:0] POLY = 5'b10011
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       shift,
  input  logic [MSG_LEN+CRC_LEN-1:0] codeword,
  output logic [CRC_LEN-1:0]         rem_next
);

  localparam int CW_LEN = MSG_LEN + CRC_LEN;

  logic [CW_LEN-1:0]  sreg;
  logic [CRC_LEN-1:0] rem;

  // The implicit x^CRC_LEN term is dropped: it is cancelled by the feedback bit itself.
  always_comb begin
    rem_next = {rem[CRC_LEN-2:0], sreg[CW_LEN-1]} ^ (rem[CRC_LEN-1] ? POLY[CRC_LEN-1:0] : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      rem  <= '0;
    end else if (load) begin
      sreg <= codeword;
      rem  <= '0;
    end else if (shift) begin
      sreg <= {sreg[CW_LEN-2:0], 1'b0};
      rem  <= rem_next;
    end
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Self-sequenced CRC frame checker: walks RAM from BASE_ADDR, checks each data word, stops on
// a terminator tag or after MAX_WORDS words. Define CRC_SYNDROME_OUT_EN to export per-word syndromes.
module crc_frame_checker
  import crc_chk_pkg::*;
#(
  parameter int MSG_LEN = 10,
  parameter int CRC_LEN = 4,
  parameter logic [CRC_LEN:0] POLY = 5'b10011,
  parameter int ADDR_W = 5,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic [ADDR_W-1:0]                  ram_addr,
  output logic                               ram_rd_en,
  input  logic [word_width(MSG_LEN,CRC_LEN)-1:0] ram_q,
  output logic                               busy,
  output logic                               done,
  output logic                               err_flag,
  output logic                               overrun,
  output logic [CNT_W-1:0]                   err_count,
  output logic [CNT_W-1:0]                   word_count,
  output logic [ADDR_W-1:0]                  first_err_addr,
  output logic [CRC_LEN-1:0]                 syndrome,
  output logic                               syn_valid
);

  localparam int CW_LEN = MSG_LEN + CRC_LEN;
  localparam int WORD_W = word_width(MSG_LEN, CRC_LEN);
  localparam int DIV_W  = $clog2(CW_LEN);
  localparam int WAIT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + MAX_WORDS - 1);

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               word_bad;
  logic [CRC_LEN-1:0] rem_next;

  crc_serial_div #(
    .MSG_LEN(MSG_LEN),
    .CRC_LEN(CRC_LEN),
    .POLY   (POLY)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_LOAD),
    .shift   (state == S_DIV),
    .codeword(ram_q[CW_LEN-1:0]),
    .rem_next(rem_next)
  );

`ifndef CRC_SYNDROME_OUT_EN
  assign syndrome  = '0;
  assign syn_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ram_addr       <= FIRST_ADDR;
      ram_rd_en      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_flag       <= 1'b0;
      overrun        <= 1'b0;
      err_count      <= '0;
      word_count     <= '0;
      first_err_addr <= '0;
      div_cnt        <= '0;
      wait_cnt       <= '0;
      word_bad       <= 1'b0;
`ifdef CRC_SYNDROME_OUT_EN
      syndrome       <= '0;
      syn_valid      <= 1'b0;
`endif
    end else begin
      ram_rd_en <= 1'b0;
      done      <= 1'b0;
`ifdef CRC_SYNDROME_OUT_EN
      syn_valid <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (start) begin
            err_flag       <= 1'b0;
            overrun        <= 1'b0;
            err_count      <= '0;
            word_count     <= '0;
            first_err_addr <= '0;
            ram_addr       <= FIRST_ADDR;
            ram_rd_en      <= 1'b1;
            busy           <= 1'b1;
            state          <= S_RD;
          end
        end
        S_RD: begin
          wait_cnt <= '0;
          state    <= (RD_LAT > 1) ? S_WAIT : S_LOAD;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_W'(RD_LAT - 2)) state <= S_LOAD;
        end
        S_LOAD: begin
          div_cnt <= '0;
          if (ram_q[WORD_W-1 -: 2] == TAG_TERM) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end
        // The final shift's remainder is captured here so EVAL sees a settled verdict.
        S_DIV: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_W'(CW_LEN - 1)) begin
            word_bad <= |rem_next;
`ifdef CRC_SYNDROME_OUT_EN
            syndrome  <= rem_next;
            syn_valid <= 1'b1;
`endif
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!(&word_count)) word_count <= word_count + 1'b1;
          if (word_bad) begin
            err_flag <= 1'b1;
            if (!(&err_count)) err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_addr <= ram_addr;
          end
          if (ram_addr == LAST_ADDR) begin
            overrun <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            ram_addr  <= ram_addr + 1'b1;
            ram_rd_en <= 1'b1;
            state     <= S_RD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench for crc_frame_checker: stimulus pushes expected scan results, a negedge
// monitor pops them on every done / syn_valid pulse. Works with or without CRC_SYNDROME_OUT_EN.
module tb_crc_frame_checker;
  import crc_chk_pkg::*;

  localparam logic [15:0] GOOD = {TAG_DATA, 14'h35BE};
  localparam logic [15:0] BAD  = {TAG_DATA, 14'h35BF};
  localparam logic [15:0] TERM = {TAG_TERM, 14'h0000};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ram_addr;
  logic        ram_rd_en;
  logic [15:0] ram_q;
  logic        busy, done, err_flag, overrun;
  logic [7:0]  err_count, word_count;
  logic [4:0]  first_err_addr;
  logic [3:0]  syndrome;
  logic        syn_valid;

  crc_frame_checker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ram_addr      (ram_addr),
    .ram_rd_en     (ram_rd_en),
    .ram_q         (ram_q),
    .busy          (busy),
    .done          (done),
    .err_flag      (err_flag),
    .overrun       (overrun),
    .err_count     (err_count),
    .word_count    (word_count),
    .first_err_addr(first_err_addr),
    .syndrome      (syndrome),
    .syn_valid     (syn_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-cycle-latency RAM model
  logic [15:0] mem [32];
  always @(posedge clk) if (ram_rd_en) ram_q <= mem[ram_addr];

  typedef struct {
    int words;
    int errs;
    int eflag;
    int ovr;
    int faddr;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   syn_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails = 0;
  int   rd_strobes = 0;
  int   last_rd_addr = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compares scan results on done and syndromes on syn_valid
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("done_cycle", cyc, mon_e.done_cyc);
        checkOutput("word_count", word_count, mon_e.words);
        checkOutput("err_count", err_count, mon_e.errs);
        checkOutput("err_flag", err_flag, mon_e.eflag);
        checkOutput("overrun", overrun, mon_e.ovr);
        checkOutput("first_err_addr", first_err_addr, mon_e.faddr);
`ifndef CRC_SYNDROME_OUT_EN
        checkOutput("syndrome_tied", syndrome, 0);
        checkOutput("syn_valid_tied", syn_valid, 0);
`endif
      end
    end
`ifdef CRC_SYNDROME_OUT_EN
    if (syn_valid) begin
      if (syn_q.size() == 0) checkOutput("unexpected_syn_valid", 1, 0);
      else checkOutput("syndrome", syndrome, syn_q.pop_front());
    end
`endif
    if (ram_rd_en) begin
      rd_strobes++;
      last_rd_addr = ram_addr;
    end
  end

  task automatic applyStimulus(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err_flag"}, err_flag, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
    checkOutput({tag, "_word_count"}, word_count, 0);
    checkOutput({tag, "_first_err_addr"}, first_err_addr, 0);
    checkOutput({tag, "_ram_addr"}, ram_addr, 0);
    checkOutput({tag, "_ram_rd_en"}, ram_rd_en, 0);
    checkOutput({tag, "_syndrome"}, syndrome, 0);
    checkOutput({tag, "_syn_valid"}, syn_valid, 0);
  endtask

  task automatic set_all(input logic [15:0] w);
    for (int i = 0; i < 32; i++) mem[i] = w;
  endtask

  task automatic push_syn(input int a, input int b, input int c);
`ifdef CRC_SYNDROME_OUT_EN
    syn_q.push_back(a);
    syn_q.push_back(b);
    syn_q.push_back(c);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, s2, base, dummy;
    rst = 1'b1;
    start = 1'b0;
    set_all(GOOD);
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: three good words then terminator");
    mem[3] = TERM;
    applyStimulus(s);
    sb.push_back('{3, 0, 0, 0, 0, s + 54});
    push_syn(0, 0, 0);
    checkOutput("t1_busy_after_start", busy, 1);
    wait_done(100);

    $display("[TB] test 2: one corrupted word at address 1");
    mem[1] = BAD;
    applyStimulus(s);
    sb.push_back('{3, 1, 1, 0, 1, s + 54});
    push_syn(0, 1, 0);
    wait_done(100);

    $display("[TB] test 3: full RAM without terminator");
    set_all(GOOD);
    base = rd_strobes;
    applyStimulus(s);
    sb.push_back('{32, 0, 0, 1, 0, s + 545});
`ifdef CRC_SYNDROME_OUT_EN
    for (int i = 0; i < 32; i++) syn_q.push_back(0);
`endif
    wait_done(700);
    checkOutput("t3_read_strobes", rd_strobes - base, 32);
    checkOutput("t3_last_rd_addr", last_rd_addr, 31);
    checkOutput("t3_ram_addr_at_done", ram_addr, 31);

    $display("[TB] test 4: terminator at address 0");
    mem[0] = TERM;
    base = rd_strobes;
    applyStimulus(s);
    sb.push_back('{0, 0, 0, 0, 0, s + 3});
    wait_done(20);
    checkOutput("t4_read_strobes", rd_strobes - base, 1);

    $display("[TB] test 5: reset during division of word 1");
    set_all(GOOD);
    mem[3] = TERM;
    applyStimulus(s);
`ifdef CRC_SYNDROME_OUT_EN
    syn_q.push_back(0);
`endif
    while (cyc < s + 25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("t5_abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(s);
    sb.push_back('{3, 0, 0, 0, 0, s + 54});
    push_syn(0, 0, 0);
    wait_done(100);

    $display("[TB] test 6: start while busy, then restart right after done");
    mem[1] = BAD;
    applyStimulus(s);
    sb.push_back('{3, 1, 1, 0, 1, s + 54});
    push_syn(0, 1, 0);
    while (cyc < s + 20) @(negedge clk);
    applyStimulus(dummy);
    wait_done(100);
    mem[1] = GOOD;
    applyStimulus(s2);
    checkOutput("t6_restart_cycle", s2, s + 55);
    checkOutput("t6_err_count_cleared", err_count, 0);
    checkOutput("t6_err_flag_cleared", err_flag, 0);
    checkOutput("t6_first_err_addr_cleared", first_err_addr, 0);
    checkOutput("t6_busy", busy, 1);
    sb.push_back('{3, 0, 0, 0, 0, s2 + 54});
    push_syn(0, 0, 0);
    wait_done(100);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    checkOutput("syndrome_queue_drained", syn_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
